serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, captured on the accepted start edge.
REQ-006 The block SHALL have port b  input  WIDTH  operand B, captured on the accepted start edge.
REQ-007 The block SHALL have port cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress (RUN state).
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port sum  output  WIDTH  registered result of the last completed addition.
REQ-011 The block SHALL have port cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL sequence one 1-bit adder cell (sum = x^y^c, carry = x&y | c&(x^y), built from two half-adder stages) over WIDTH cycles, LSB first.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, encoded internally.
REQ-014 IDLE -> RUN SHALL occur on an edge with start=1; that edge loads a, b into operand shift registers, cin into the carry flop, and clears the bit counter to 0.
REQ-015 In RUN, each edge SHALL add operand bit 0 of each shift register with the carry flop, shift the result bit into a result shift register from the MSB side, update the carry flop, shift both operands right, and increment the counter.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1 (the WIDTH-th RUN edge); that same edge SHALL copy the completed result to sum and the final carry to cout.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE (one cycle).
REQ-019 Latency: start accepted at edge E0 -> done high in the cycle following edge E0+WIDTH; next start accepted no earlier than edge E0+WIDTH+2.
REQ-020 start while in RUN or DONE SHALL be ignored with no effect on state, operands or outputs.
REQ-021 Changes on a, b or cin after the accepted start edge SHALL not affect the in-progress result.
REQ-022 sum and cout SHALL hold their value from one completion until the next completion or reset; they SHALL not change during RUN.
REQ-023 Arithmetic: {cout, sum} SHALL equal a + b + cin modulo 2^(WIDTH+1), no saturation.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL not wrap during RUN.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, regardless of state.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no update of sum/cout other than to 0.
REQ-027 rst SHALL have priority over start on the same edge.

Verification
REQ-028 WIDTH=8: a=0x0F, b=0x01, cin=0, start 1 cycle -> busy high 8 cycles, done 1 cycle after edge E0+8, sum=0x10, cout=0.
REQ-029 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-030 WIDTH=8: start pulsed again at RUN cycle 3 and in DONE, with a/b changed to 0xAA/0x55 -> ignored; original result delivered, exactly one done pulse.
REQ-031 WIDTH=8: rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse follows.
REQ-032 WIDTH=8: back-to-back 0x80+0x80 then 0x01+0x02, second start at earliest legal edge -> first done sum=0x00 cout=1, second done sum=0x03 cout=0, sum stable between pulses.
REQ-033 Randomized check for WIDTH in {2, 8, 32}: 1000 random a, b, cin -> {cout, sum} matches a+b+cin on every done pulse.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first over WIDTH cycles.
// Results land in sum/cout on the last RUN edge and are held until the next completion.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Full adder built from two half-adder stages.
  logic hs1, hc1, bit_s, hc2, bit_c;
  assign hs1   = opa_q[0] ^ opb_q[0];
  assign hc1   = opa_q[0] & opb_q[0];
  assign bit_s = hs1 ^ carry_q;
  assign hc2   = hs1 & carry_q;
  assign bit_c = hc1 | hc2;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      StRun: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH 2, 8 and 32; results are scoreboarded at each done pulse.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_v [3];
  logic        cin_v   [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  wire         busy_v  [3];
  wire         done_v  [3];
  wire         cout_v  [3];
  wire  [31:0] sum_v   [3];

  logic [63:0] exp_q  [3][$];
  logic [63:0] last_v [3];

  int checks   = 0;
  int failures = 0;

  function automatic int wof(int k);
    return (k == 0) ? 2 : ((k == 1) ? 8 : 32);
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] result(int k);
    return 64'(sum_v[k]) | (64'(cout_v[k]) << wof(k));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 32);
    logic [W-1:0] s;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .a     (a_v[g][W-1:0]),
      .b     (b_v[g][W-1:0]),
      .cin   (cin_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .sum   (s),
      .cout  (cout_v[g])
    );
    assign sum_v[g] = 32'(s);

    always @(negedge clk) begin
      if (done_v[g]) begin
        if (exp_q[g].size() == 0) check($sformatf("unexpected_done_w%0d", W), 64'(done_v[g]), 0);
        else check($sformatf("result_w%0d", W), result(g), exp_q[g].pop_front());
      end
    end
  end

  // Entered just after a negedge with the instance idle; leaves it idle one cycle after done,
  // so a following call starts on the earliest legal edge.
  task automatic op(int k, logic [31:0] av, logic [31:0] bv, logic c, bit poke, int rst_at);
    int          w = wof(k);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] e = (64'(av) & m) + (64'(bv) & m) + 64'(c);
    start_v[k] = 1'b1;
    a_v[k]     = av;
    b_v[k]     = bv;
    cin_v[k]   = c;
    if (rst_at < 0) exp_q[k].push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int i = 0; i < w; i++) begin
      check("busy_run", 64'(busy_v[k]), 1);
      check("done_run", 64'(done_v[k]), 0);
      check("hold_run", result(k), last_v[k]);
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy_v[k]), 0);
        check("rst_done", 64'(done_v[k]), 0);
        check("rst_sum", 64'(sum_v[k]), 0);
        check("rst_cout", 64'(cout_v[k]), 0);
        last_v[k] = '0;
        return;
      end
      if (poke && i == 2) begin
        start_v[k] = 1'b1;
        a_v[k]     = 32'hAA;
        b_v[k]     = 32'h55;
        cin_v[k]   = ~c;
      end
      if (poke && i == 3) start_v[k] = 1'b0;
      @(negedge clk);
    end
    check("done_pulse", 64'(done_v[k]), 1);
    check("busy_done", 64'(busy_v[k]), 0);
    last_v[k] = e;
    if (poke) start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check("done_drop", 64'(done_v[k]), 0);
    check("busy_idle", 64'(busy_v[k]), 0);
  endtask

  task automatic rand_run(int k);
    for (int n = 0; n < 1000; n++) op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, -1);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      cin_v[k]   = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
      last_v[k]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", 64'(busy_v[k]), 0);
      check("reset_done", 64'(done_v[k]), 0);
      check("reset_result", result(k), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    op(1, 32'h0F, 32'h01, 1'b0, 1'b0, -1);
    op(1, 32'hFF, 32'h01, 1'b0, 1'b0, -1);
    op(1, 32'hFF, 32'h00, 1'b1, 1'b0, -1);
    op(1, 32'h3C, 32'h0F, 1'b1, 1'b1, -1);
    op(1, 32'h21, 32'h42, 1'b0, 1'b0, 3);
    repeat (12) @(negedge clk);
    check("post_abort_sum", result(1), 0);
    op(1, 32'h80, 32'h80, 1'b0, 1'b0, -1);
    op(1, 32'h01, 32'h02, 1'b0, 1'b0, -1);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) check("drained", 64'(exp_q[k].size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
